ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo_pkg.sv | 9 +
 rtl/ps2_rx_fifo_if.sv | 14 +
 rtl/ps2_input_filter.sv | 30 +++
 rtl/ps2_rx_fifo.sv | 102 ++++++++++
 tb/tb_ps2_rx_fifo.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared frame constants, FSM state encoding and parity helper for the PS/2 receiver
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2State_t;
  function automatic logic parityOk(input logic [DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: FIFO read side (iRead, iClearErr, oScanCode, oValid, oFull) plus sticky error flags; slave = receiver, master = consumer
interface ps2_rx_fifo_if;
  import ps2_pkg::*;
  logic iRead;
  logic iClearErr;
  logic [DATA_W-1:0] oScanCode;
  logic oValid;
  logic oFull;
  logic oParityErr;
  logic oFrameErr;
  logic oOverflow;
  modport slave(input iRead, iClearErr, output oScanCode, oValid, oFull, oParityErr, oFrameErr, oOverflow);
  modport master(output iRead, iClearErr, input oScanCode, oValid, oFull, oParityErr, oFrameErr, oOverflow);
endinterface

// File: rtl/ps2_input_filter.sv
// ps2_input_filter: synchronizer chain (clock, reset, iRaw) then a level filter (oFilt) that flips only after FILTER_LEN consecutive differing samples
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic iRaw,
  output logic oFilt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [SYNC_STAGES-1:0] syncReg;
  logic [CW-1:0] runLen;
  logic syncOut;
  assign syncOut = syncReg[SYNC_STAGES-1];
  always_ff @(posedge clock) begin
    if (reset) begin
      syncReg <= '1;
      runLen <= '0;
      oFilt <= 1'b1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], iRaw};
      if (syncOut == oFilt) runLen <= '0;
      else if (runLen == CW'(FILTER_LEN - 1)) begin
        oFilt <= syncOut;
        runLen <= '0;
      end else runLen <= runLen + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver into a FWFT scan-code FIFO; ports clock/reset, raw iPS2clk/iPS2data, bus (read side + sticky error flags)
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clock,
  input logic reset,
  input logic iPS2clk,
  input logic iPS2data,
  ps2_rx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2State_t state, stateNext;
  logic ps2ClkFilt, ps2ClkPrev, fallEdge, dataBit;
  logic [SYNC_STAGES-1:0] dataSync;
  logic [DATA_W-1:0] shiftReg;
  logic [2:0] bitCnt;
  logic parityBit;
  logic [TW-1:0] timer;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0] count;
  logic timeout, frameDone, stopBad, parityBad, goodFrame, full, notEmpty, doPop, doPush;
  logic parityErr, frameErr, overflow;
  ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) clkFilter (
    .clock(clock),
    .reset(reset),
    .iRaw(iPS2clk),
    .oFilt(ps2ClkFilt)
  );
  assign fallEdge = ps2ClkPrev & ~ps2ClkFilt;
  assign dataBit = dataSync[SYNC_STAGES-1];
  always_comb begin
    timeout = state != IDLE && !fallEdge && timer == TW'(TIMEOUT_CYCLES);
    frameDone = state == STOP && fallEdge;
    stopBad = frameDone && !dataBit;
    parityBad = frameDone && dataBit && !parityOk(shiftReg, parityBit);
    goodFrame = frameDone && dataBit && parityOk(shiftReg, parityBit);
    full = count == (PTR_W+1)'(FIFO_DEPTH);
    notEmpty = count != '0;
    doPop = bus.iRead && notEmpty;
    doPush = goodFrame && (!full || doPop);
    stateNext = state;
    if (timeout) stateNext = IDLE;
    else if (fallEdge) begin
      unique case (state)
        IDLE:    stateNext = dataBit ? IDLE : DATA;
        DATA:    stateNext = bitCnt == 3'd7 ? PARITY : DATA;
        PARITY:  stateNext = STOP;
        default: stateNext = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ps2ClkPrev <= 1'b1;
      dataSync <= '1;
      shiftReg <= '0;
      bitCnt <= '0;
      parityBit <= 1'b0;
      timer <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      parityErr <= 1'b0;
      frameErr <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= stateNext;
      ps2ClkPrev <= ps2ClkFilt;
      dataSync <= {dataSync[SYNC_STAGES-2:0], iPS2data};
      timer <= (state == IDLE || fallEdge) ? '0 : timer + 1'b1;
      if (fallEdge && state == IDLE) bitCnt <= '0;
      if (fallEdge && state == DATA) begin
        shiftReg <= {dataBit, shiftReg[DATA_W-1:1]};
        bitCnt <= bitCnt + 1'b1;
      end
      if (fallEdge && state == PARITY) parityBit <= dataBit;
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
      parityErr <= (parityErr & ~bus.iClearErr) | parityBad;
      frameErr <= (frameErr & ~bus.iClearErr) | stopBad | timeout;
      overflow <= (overflow & ~bus.iClearErr) | (goodFrame & full & ~doPop);
    end
  end
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= shiftReg;
  end
  assign bus.oScanCode = notEmpty ? mem[rdPtr] : '0;
  assign bus.oValid = notEmpty;
  assign bus.oFull = full;
  assign bus.oParityErr = parityErr;
  assign bus.oFrameErr = frameErr;
  assign bus.oOverflow = overflow;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized and directed PS/2 frames checked against a queue-based model of the receiver FIFO
module tb_ps2_rx_fifo;
  import ps2_pkg::*;
  localparam int DEPTH = 4, SYNC = 2, FLEN = 4, TMO = 400, HALF = 16;
  localparam int PUSH_AT = SYNC + FLEN;
  logic clk = 0, rst = 1, ps2Clk = 1, ps2Data = 1;
  int errors = 0, checks = 0;
  byte unsigned q[$];
  logic mParity = 0, mFrame = 0, mOverflow = 0;
  ps2_rx_fifo_if bus();
  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clk),
    .reset(rst),
    .iPS2clk(ps2Clk),
    .iPS2data(ps2Data),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic checkAll(input string tag);
    checkVal({tag, ".valid"}, 32'(bus.oValid), 32'(q.size() != 0));
    checkVal({tag, ".head"}, 32'(bus.oScanCode), q.size() != 0 ? 32'(q[0]) : 32'd0);
    checkVal({tag, ".full"}, 32'(bus.oFull), 32'(q.size() == DEPTH));
    checkVal({tag, ".perr"}, 32'(bus.oParityErr), 32'(mParity));
    checkVal({tag, ".ferr"}, 32'(bus.oFrameErr), 32'(mFrame));
    checkVal({tag, ".ovf"}, 32'(bus.oOverflow), 32'(mOverflow));
  endtask
  function automatic logic oddPar(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction
  task automatic ps2Bit(input logic b, input int glitchLen, input int readAt);
    ps2Data = b;
    for (int i = 0; i < HALF; i++) begin
      if (glitchLen > 0 && i == 4) ps2Clk = 0;
      if (glitchLen > 0 && i == 4 + glitchLen) ps2Clk = 1;
      @(negedge clk);
    end
    ps2Clk = 0;
    for (int i = 0; i < HALF; i++) begin
      bus.iRead = (i == readAt);
      if (glitchLen > 0 && i == 8) ps2Clk = 1;
      if (glitchLen > 0 && i == 8 + glitchLen) ps2Clk = 0;
      @(negedge clk);
    end
    bus.iRead = 0;
    ps2Clk = 1;
  endtask
  task automatic modelFrame(input logic [7:0] d, input logic par, input logic stop, input bit popFirst);
    if (popFirst && q.size() != 0) void'(q.pop_front());
    if (!stop) mFrame = 1;
    else if ($countones({d, par}) % 2 == 0) mParity = 1;
    else if (q.size() < DEPTH) q.push_back(d);
    else mOverflow = 1;
  endtask
  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop, input int nBits, input int glitchLen, input int readAt);
    logic [FRAME_BITS-1:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nBits; i++) ps2Bit(f[i], glitchLen, i == FRAME_BITS - 1 ? readAt : -1);
    ps2Data = 1;
    repeat (20) @(negedge clk);
    if (nBits == FRAME_BITS) modelFrame(d, par, stop, readAt >= 0);
  endtask
  task automatic good(input logic [7:0] d);
    sendFrame(d, oddPar(d), 1, FRAME_BITS, 0, -1);
  endtask
  task automatic readOne();
    bus.iRead = 1;
    @(negedge clk);
    bus.iRead = 0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic clearErr();
    bus.iClearErr = 1;
    @(negedge clk);
    bus.iClearErr = 0;
    mParity = 0;
    mFrame = 0;
    mOverflow = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [FRAME_BITS-1:0] f;
    logic [7:0] d;
    logic par, stop;
    bus.iRead = 0;
    bus.iClearErr = 0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst = 0;
    @(negedge clk);
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < FRAME_BITS - 1; i++) ps2Bit(f[i], 0, -1);
    ps2Data = 1;
    repeat (HALF) @(negedge clk);
    ps2Clk = 0;
    repeat (PUSH_AT) @(negedge clk);
    checkVal("lat.before", 32'(bus.oValid), 32'd0);
    @(negedge clk);
    checkVal("lat.valid", 32'(bus.oValid), 32'd1);
    checkVal("lat.head", 32'(bus.oScanCode), 32'h1C);
    repeat (HALF - PUSH_AT - 1) @(negedge clk);
    ps2Clk = 1;
    repeat (20) @(negedge clk);
    q.push_back(8'h1C);
    checkAll("first");
    readOne();
    checkAll("firstRead");
    good(8'hF0);
    good(8'h1C);
    checkAll("two");
    readOne();
    checkAll("twoRead1");
    readOne();
    checkAll("twoRead2");
    readOne();
    checkAll("emptyRead");
    sendFrame(8'h1C, 1, 1, FRAME_BITS, 0, -1);
    checkAll("parErr");
    clearErr();
    checkAll("parClr");
    sendFrame(8'h55, oddPar(8'h55), 0, FRAME_BITS, 0, -1);
    checkAll("stopErr");
    clearErr();
    for (int i = 0; i < DEPTH + 1; i++) good(8'(8'h30 + i));
    checkAll("overflow");
    good(8'h77);
    sendFrame(8'h99, oddPar(8'h99), 1, FRAME_BITS, 0, PUSH_AT);
    checkAll("fullPushPop");
    repeat (DEPTH + 1) begin
      readOne();
      checkAll("drain");
    end
    clearErr();
    sendFrame(8'h00, 0, 1, 5, 0, -1);
    repeat (TMO + 50) @(negedge clk);
    mFrame = 1;
    checkAll("timeout");
    checkVal("timeoutIdle", 32'(dut.state), 32'(IDLE));
    good(8'h1C);
    checkAll("afterTimeout");
    readOne();
    clearErr();
    sendFrame(8'hA5, oddPar(8'hA5), 1, FRAME_BITS, FLEN - 1, -1);
    checkAll("glitch");
    readOne();
    good(8'h42);
    sendFrame(8'h33, oddPar(8'h33), 1, 6, 0, -1);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
    mParity = 0;
    mFrame = 0;
    mOverflow = 0;
    checkAll("midReset");
    good(8'h5A);
    checkAll("afterReset");
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      par = $urandom_range(0, 9) < 8 ? oddPar(d) : ~oddPar(d);
      stop = $urandom_range(0, 19) != 0;
      sendFrame(d, par, stop, FRAME_BITS, $urandom_range(0, 1) != 0 ? int'($urandom_range(1, FLEN - 1)) : 0, -1);
      checkAll("rand");
      repeat ($urandom_range(0, 2)) begin
        readOne();
        checkAll("randRead");
      end
      if ($urandom_range(0, 4) == 0) clearErr();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
